// File: rtl/multiplier_8bit.sv
// multiplier_8bit: sequential unsigned WIDTH x WIDTH multiplier, radix-4
// shift-add (two multiplier bits per clock, WIDTH/2 compute cycles).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   a        in   multiplicand (unsigned, WIDTH)
//   b        in   multiplier   (unsigned, WIDTH)
//   start    in   level request; operands reload on every edge it is high
//   ab       out  product register (2*WIDTH), last completed result
//   working  out  high from the first start edge until the product is written
module multiplier_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  output logic [2*WIDTH-1:0] ab,
  output logic               working
);

  localparam int ITERS = WIDTH / 2;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   ab_q, ab_d;
  logic                 working_q, working_d;

  // Radix-4 digit times multiplicand: 0, m, 2m or 3m (= m + 2m).
  logic [1:0]           digit;
  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH-1:0]   pp_sh;
  logic [2*WIDTH-1:0]   sum;

  always_comb begin
    digit = mplier_q[1:0];
    pp    = (digit[0] ? {2'b00, mcand_q} : '0)
          + (digit[1] ? {1'b0, mcand_q, 1'b0} : '0);
    // Align the partial product at bit 2*counter.
    pp_sh = (2*WIDTH)'(pp) << {cnt_q, 1'b0};
    sum   = acc_q + pp_sh;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ab_d      = ab_q;
    working_d = working_q;

    if (start) begin
      // Any state: (re)load operands, abandoning an in-flight product.
      state_d   = LOAD;
      mcand_d   = a;
      mplier_d  = b;
      acc_d     = '0;
      cnt_d     = '0;
      working_d = 1'b1;
    end else begin
      case (state_q)
        // Leaving LOAD performs iteration 0 on the same edge.
        LOAD, BUSY: begin
          acc_d    = sum;
          mplier_d = mplier_q >> 2;
          cnt_d    = cnt_q + 1'b1;
          state_d  = BUSY;
          if (cnt_q == LAST) begin
            ab_d      = sum;
            working_d = 1'b0;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ab_q      <= '0;
      working_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ab_q      <= ab_d;
      working_q <= working_d;
    end
  end

  assign ab      = ab_q;
  assign working = working_q;

endmodule

// File: tb/tb_multiplier_8bit.sv
module tb_multiplier_8bit;

  logic        clk, rst, start;
  logic [7:0]  a, b;
  logic [15:0] ab;
  logic        working;

  int total = 0;
  int bad   = 0;

  multiplier_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
    .ab(ab), .working(working)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold start for nload edges with the given operands, then drop it and
  // check working/ab over the four compute edges. With scramble set, a/b
  // are changed after the first compute edge; the product must not move.
  task automatic run_mul(input logic [7:0] ai, input logic [7:0] bi, input int nload,
                         input logic [15:0] prev, input logic [15:0] exp,
                         input bit scramble);
    a = ai; b = bi; start = 1'b1;
    for (int i = 0; i < nload; i++) begin
      step();
      chk("load_working", working, 1);
      chk("load_ab_hold", ab, prev);
    end
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (scramble) begin a = 8'hff; b = 8'hff; end
      chk("busy_working", working, 1);
      chk("busy_ab_hold", ab, prev);
    end
    step();
    chk("done_ab", ab, exp);
    chk("done_working", working, 0);
    step();
    chk("idle_ab_hold", ab, exp);
    chk("idle_working", working, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_ab", ab, 0);
    chk("rst_working", working, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ab", ab, 0);

    run_mul(8'd3,   8'd17,  3, 16'd0,   16'd51,    1'b0);
    run_mul(8'd255, 8'd1,   1, 16'd51,  16'd255,   1'b0);
    run_mul(8'd255, 8'd255, 1, 16'd255, 16'd65025, 1'b0);
    run_mul(8'd0,   8'd200, 2, 16'd65025, 16'd0,   1'b0);
    run_mul(8'd128, 8'd2,   1, 16'd0,   16'd256,   1'b0);

    // Restart during the second BUSY cycle: 10*10 must never appear.
    a = 8'd10; b = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_ab_hold", ab, 256);
    chk("abort_working", working, 1);
    run_mul(8'd6, 8'd7, 1, 16'd256, 16'd42, 1'b0);

    // Asynchronous reset between edges during BUSY.
    a = 8'd100; b = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ab", ab, 0);
    chk("async_rst_working", working, 0);
    step();
    chk("rst_held_ab", ab, 0);
    rst = 1'b0;
    run_mul(8'd5, 8'd9, 1, 16'd0, 16'd45, 1'b0);

    // Operands changed during BUSY must not affect the product.
    run_mul(8'd12, 8'd11, 1, 16'd45, 16'd132, 1'b1);

    // Start held continuously: never completes.
    a = 8'd2; b = 8'd2; start = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("held_working", working, 1);
    chk("held_ab", ab, 132);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("held_release_ab", ab, 4);
    chk("held_release_working", working, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
